// File: rtl/gcd_job_scheduler_if.sv
// Requester, response, engine CSR and status signals of the GCD job scheduler.
// The master modport is the scheduler's view; slave is the surrounding system.
interface gcd_job_scheduler_if #(
    parameter int NUM_REQ = 4
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ-1:0][63:0] req_a;
    logic [NUM_REQ-1:0][63:0] req_b;

    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [ID_W-1:0]          rsp_id;
    logic [63:0]              rsp_result;

    logic                     avm_read;
    logic                     avm_write;
    logic [2:0]               avm_address;
    logic [31:0]              avm_writedata;
    logic [31:0]              avm_readdata;

    logic                     busy;
    logic [31:0]              job_count;

    modport master (
        input  req_valid, req_a, req_b, rsp_ready, avm_readdata,
        output req_ready, rsp_valid, rsp_id, rsp_result,
               avm_read, avm_write, avm_address, avm_writedata, busy, job_count
    );

    modport slave (
        output req_valid, req_a, req_b, rsp_ready, avm_readdata,
        input  req_ready, rsp_valid, rsp_id, rsp_result,
               avm_read, avm_write, avm_address, avm_writedata, busy, job_count
    );
endinterface

// File: rtl/gcd_job_scheduler.sv
// Round-robin front end sharing one CSR-mapped 64-bit GCD engine among NUM_REQ requesters.
// Zero operands are answered locally since the engine would never finish on them.
module gcd_job_scheduler #(
    parameter int NUM_REQ  = 4,
    parameter int POLL_GAP = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    gcd_job_scheduler_if.master   bus
);
    localparam int ID_W = $clog2(NUM_REQ);
    localparam logic [7:0] GAP_LAST = (POLL_GAP > 0) ? 8'(POLL_GAP - 1) : 8'd0;

    typedef enum logic [3:0] {
        IDLE, WR_ALO, WR_AHI, WR_BLO, WR_BHI, POLL_RD, POLL_CHK, POLL_WAIT,
        RD_LO, RD_HI, CAP_HI, RESP
    } state_e;

    state_e          state_q, state_d;
    logic [63:0]     a_q, a_d, b_q, b_d;
    logic [ID_W-1:0] id_q, id_d, last_q, last_d;
    logic [7:0]      gap_q, gap_d;
    logic [31:0]     lo_q, lo_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0] rsp_id_q, rsp_id_d;
    logic [63:0]     rsp_result_q, rsp_result_d;
    logic            avm_read_q, avm_read_d, avm_write_q, avm_write_d;
    logic [2:0]      avm_addr_q, avm_addr_d;
    logic [31:0]     avm_wdata_q, avm_wdata_d;
    logic            busy_q, busy_d;
    logic [31:0]     job_cnt_q, job_cnt_d;

    logic            gnt_found;
    logic [ID_W-1:0] gnt_idx;
    logic [ID_W:0]   sum;

    // First valid requester after last_q, wrapping around NUM_REQ.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        sum       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            sum = {1'b0, last_q} + (ID_W+1)'(k);
            if (sum >= (ID_W+1)'(NUM_REQ)) sum = sum - (ID_W+1)'(NUM_REQ);
            if (!gnt_found && bus.req_valid[sum[ID_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = sum[ID_W-1:0];
            end
        end
    end

    assign bus.req_ready = (reset_n && state_q == IDLE && gnt_found) ?
                           (NUM_REQ'(1) << gnt_idx) : '0;

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        id_d         = id_q;
        last_d       = last_q;
        gap_d        = gap_q;
        lo_d         = lo_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        job_cnt_d    = job_cnt_q;

        unique case (state_q)
            IDLE: if (gnt_found) begin
                a_d  = bus.req_a[gnt_idx];
                b_d  = bus.req_b[gnt_idx];
                id_d = gnt_idx;
                if (a_d == 64'd0 || b_d == 64'd0) begin
                    state_d      = RESP;
                    rsp_valid_d  = 1'b1;
                    rsp_id_d     = gnt_idx;
                    rsp_result_d = a_d | b_d;
                end else begin
                    state_d = WR_ALO;
                end
            end
            WR_ALO:  state_d = WR_AHI;
            WR_AHI:  state_d = WR_BLO;
            WR_BLO:  state_d = WR_BHI;
            WR_BHI:  state_d = POLL_RD;
            POLL_RD: state_d = POLL_CHK;
            POLL_CHK: begin
                if (bus.avm_readdata == 32'd0) state_d = RD_LO;
                else if (POLL_GAP == 0)         state_d = POLL_RD;
                else begin
                    state_d = POLL_WAIT;
                    gap_d   = GAP_LAST;
                end
            end
            POLL_WAIT: begin
                if (gap_q == 8'd0) state_d = POLL_RD;
                else               gap_d   = gap_q - 8'd1;
            end
            RD_LO: state_d = RD_HI;
            RD_HI: begin
                lo_d    = bus.avm_readdata;
                state_d = CAP_HI;
            end
            CAP_HI: begin
                state_d      = RESP;
                rsp_valid_d  = 1'b1;
                rsp_id_d     = id_q;
                rsp_result_d = {bus.avm_readdata, lo_q};
            end
            RESP: if (bus.rsp_ready) begin
                state_d      = IDLE;
                rsp_valid_d  = 1'b0;
                rsp_id_d     = '0;
                rsp_result_d = '0;
                job_cnt_d    = job_cnt_q + 32'd1;
                last_d       = id_q;
            end
            default: state_d = IDLE;
        endcase

        // Bus strobes are registered: decode them from the state being entered.
        avm_read_d  = 1'b0;
        avm_write_d = 1'b0;
        avm_addr_d  = 3'd0;
        avm_wdata_d = 32'd0;
        unique case (state_d)
            WR_ALO:  begin avm_write_d = 1'b1; avm_addr_d = 3'd1; avm_wdata_d = a_d[31:0];  end
            WR_AHI:  begin avm_write_d = 1'b1; avm_addr_d = 3'd2; avm_wdata_d = a_d[63:32]; end
            WR_BLO:  begin avm_write_d = 1'b1; avm_addr_d = 3'd3; avm_wdata_d = b_d[31:0];  end
            WR_BHI:  begin avm_write_d = 1'b1; avm_addr_d = 3'd4; avm_wdata_d = b_d[63:32]; end
            POLL_RD: begin avm_read_d  = 1'b1; avm_addr_d = 3'd0; end
            RD_LO:   begin avm_read_d  = 1'b1; avm_addr_d = 3'd1; end
            RD_HI:   begin avm_read_d  = 1'b1; avm_addr_d = 3'd2; end
            default: ;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            id_q         <= '0;
            last_q       <= ID_W'(NUM_REQ - 1);
            gap_q        <= '0;
            lo_q         <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            avm_read_q   <= 1'b0;
            avm_write_q  <= 1'b0;
            avm_addr_q   <= '0;
            avm_wdata_q  <= '0;
            busy_q       <= 1'b0;
            job_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            id_q         <= id_d;
            last_q       <= last_d;
            gap_q        <= gap_d;
            lo_q         <= lo_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            avm_read_q   <= avm_read_d;
            avm_write_q  <= avm_write_d;
            avm_addr_q   <= avm_addr_d;
            avm_wdata_q  <= avm_wdata_d;
            busy_q       <= busy_d;
            job_cnt_q    <= job_cnt_d;
        end
    end

    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_id        = rsp_id_q;
    assign bus.rsp_result    = rsp_result_q;
    assign bus.avm_read      = avm_read_q;
    assign bus.avm_write     = avm_write_q;
    assign bus.avm_address   = avm_addr_q;
    assign bus.avm_writedata = avm_wdata_q;
    assign bus.busy          = busy_q;
    assign bus.job_count     = job_cnt_q;
endmodule

// File: tb/tb_gcd_job_scheduler.sv
// Bench for gcd_job_scheduler: CSR engine model, cycle-level job model derived from the
// documented timing, directed cases and a randomized traffic phase.
module tb_gcd_job_scheduler;
    localparam int NUM_REQ  = 4;
    localparam int POLL_GAP = 4;
    localparam int P        = POLL_GAP + 2;
    localparam int ID_W     = $clog2(NUM_REQ);

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    gcd_job_scheduler_if #(.NUM_REQ(NUM_REQ)) bus ();
    gcd_job_scheduler #(.NUM_REQ(NUM_REQ), .POLL_GAP(POLL_GAP)) dut (
        .clock(clock), .reset_n(reset_n), .bus(bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 40) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] gcd64(input logic [63:0] x, input logic [63:0] y);
        logic [63:0] t;
        if (x == 0) return y;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // ---------------- engine CSR model ----------------
    logic [63:0] eA, eB;
    int          ecnt;
    int          eng_next_lat = 0;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            eA <= '0; eB <= '0; ecnt <= 0;
            bus.avm_readdata <= '0;
        end else begin
            if (bus.avm_read) begin
                case (bus.avm_address)
                    3'd0: bus.avm_readdata <= (ecnt != 0) ? 32'h1 : 32'h0;
                    3'd1: bus.avm_readdata <= eA[31:0];
                    3'd2: bus.avm_readdata <= eA[63:32];
                    3'd3: bus.avm_readdata <= eB[31:0];
                    3'd4: bus.avm_readdata <= eB[63:32];
                    default: bus.avm_readdata <= 32'h0;
                endcase
            end else begin
                bus.avm_readdata <= 32'hDEAD_BEEF;
            end
            if (ecnt != 0) ecnt <= ecnt - 1;
            if (bus.avm_write && ecnt == 0) begin
                case (bus.avm_address)
                    3'd1: eA[31:0]  <= bus.avm_writedata;
                    3'd2: eA[63:32] <= bus.avm_writedata;
                    3'd3: eB[31:0]  <= bus.avm_writedata;
                    3'd4: begin
                        ecnt <= eng_next_lat;
                        eA   <= gcd64(eA, {bus.avm_writedata, eB[31:0]});
                        eB   <= gcd64(eA, {bus.avm_writedata, eB[31:0]});
                    end
                    default: ;
                endcase
            end
        end
    end

    // ---------------- job model and per-cycle compare ----------------
    bit              m_active = 0;
    int              m_c = 0, m_T = 0, m_k = 0;
    logic [ID_W-1:0] m_id = '0;
    logic [ID_W-1:0] m_last = ID_W'(NUM_REQ - 1);
    logic [63:0]     m_a = '0, m_b = '0;
    bit              m_byp = 0;
    logic [31:0]     m_jobs = '0;
    int              hs_cnt = 0;
    int              acc_seen [NUM_REQ];
    int              grants [$];
    logic [63:0]     last_res = '0;
    logic [ID_W-1:0] last_id = '0;
    int              rsp_cyc = -1;
    logic [2:0]      wlog_addr [$];
    logic [31:0]     wlog_data [$];
    int              force_lat = -1;

    logic [NUM_REQ-1:0] exp_rr;
    logic [ID_W-1:0]    gidx, cand;
    bit                 e_rd, e_wr, e_rv;
    logic [2:0]         e_addr;
    logic [31:0]        e_wd;
    int                 lat;

    always @(negedge clock) begin
        if (!reset_n) begin
            m_active = 0;
            m_last   = ID_W'(NUM_REQ - 1);
            m_jobs   = '0;
        end else begin
            exp_rr = '0;
            gidx   = '0;
            if (!m_active) begin
                for (int k = 1; k <= NUM_REQ; k++) begin
                    cand = ID_W'((int'(m_last) + k) % NUM_REQ);
                    if (exp_rr == '0 && bus.req_valid[cand]) begin
                        exp_rr[cand] = 1'b1;
                        gidx = cand;
                    end
                end
            end
            chk("req_ready", 64'(bus.req_ready), 64'(exp_rr));

            e_rd = 0; e_wr = 0; e_addr = '0; e_wd = '0;
            if (m_active && !m_byp && m_c >= 1 && m_c < m_T) begin
                if (m_c <= 4) begin
                    e_wr   = 1;
                    e_addr = 3'(m_c);
                    e_wd   = (m_c == 1) ? m_a[31:0] : (m_c == 2) ? m_a[63:32] :
                             (m_c == 3) ? m_b[31:0] : m_b[63:32];
                end else if (m_c >= 5 && (m_c - 5) % P == 0 && (m_c - 5) / P <= m_k) begin
                    e_rd = 1;
                end else if (m_c == m_T - 3) begin
                    e_rd = 1; e_addr = 3'd1;
                end else if (m_c == m_T - 2) begin
                    e_rd = 1; e_addr = 3'd2;
                end
            end
            chk("avm_read", 64'(bus.avm_read), 64'(e_rd));
            chk("avm_write", 64'(bus.avm_write), 64'(e_wr));
            chk("avm_address", 64'(bus.avm_address), 64'(e_addr));
            chk("avm_writedata", 64'(bus.avm_writedata), 64'(e_wd));

            e_rv = m_active && m_c >= m_T;
            chk("rsp_valid", 64'(bus.rsp_valid), 64'(e_rv));
            if (e_rv) begin
                chk("rsp_id", 64'(bus.rsp_id), 64'(m_id));
                chk("rsp_result", bus.rsp_result, gcd64(m_a, m_b));
            end
            chk("busy", 64'(bus.busy), 64'(m_active && m_c >= 1));
            chk("job_count", 64'(bus.job_count), 64'(m_jobs));

            if (m_active && bus.rsp_valid && rsp_cyc < 0) rsp_cyc = m_c;
            if (m_active && bus.avm_write) begin
                wlog_addr.push_back(bus.avm_address);
                wlog_data.push_back(bus.avm_writedata);
            end

            if (m_active && e_rv && bus.rsp_ready) begin
                m_jobs   = m_jobs + 32'd1;
                m_last   = m_id;
                m_active = 0;
                last_res = bus.rsp_result;
                last_id  = bus.rsp_id;
                hs_cnt++;
            end else if (m_active) begin
                m_c++;
            end else if (exp_rr != '0) begin
                m_active = 1;
                m_c      = 1;
                m_id     = gidx;
                m_a      = bus.req_a[gidx];
                m_b      = bus.req_b[gidx];
                m_byp    = (m_a == 0 || m_b == 0);
                rsp_cyc  = -1;
                wlog_addr.delete();
                wlog_data.delete();
                acc_seen[gidx]++;
                grants.push_back(int'(gidx));
                if (m_byp) begin
                    m_T = 1; m_k = 0;
                end else begin
                    lat = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 12));
                    eng_next_lat = lat;
                    m_k = (lat == 0) ? 0 : ((lat - 1) / P + 1);
                    m_T = 10 + m_k * P;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [63:0] opa [NUM_REQ];
    logic [63:0] opb [NUM_REQ];
    bit          vld [NUM_REQ];
    int          acc_used [NUM_REQ];
    bit          rdy = 1, refill = 0, rnd_mode = 0;

    task automatic drive();
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_valid[i] = vld[i];
            bus.req_a[i]     = opa[i];
            bus.req_b[i]     = opb[i];
        end
        bus.rsp_ready = rdy;
    endtask

    task automatic new_job(input int i, input logic [63:0] a, input logic [63:0] b);
        opa[i] = a; opb[i] = b; vld[i] = 1;
    endtask

    task automatic new_rand_job(input int i);
        logic [63:0] a, b, g;
        case ($urandom_range(0, 5))
            0: begin a = 64'd0; b = {32'($urandom), 32'($urandom)}; end
            1: begin a = 64'($urandom_range(0, 3)); b = 64'd0; end
            2: begin a = 64'($urandom_range(1, 1000)); b = 64'($urandom_range(1, 1000)); end
            3: begin a = {32'($urandom), 32'($urandom)} | 64'd1; b = {32'($urandom), 32'($urandom)} | 64'd2; end
            4: begin
                g = 64'($urandom_range(1, 1 << 20));
                a = g * 64'($urandom_range(1, 1 << 20));
                b = g * 64'($urandom_range(1, 1 << 20));
            end
            default: begin a = 64'd1 << $urandom_range(0, 63); b = 64'd3 << $urandom_range(0, 60); end
        endcase
        new_job(i, a, b);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (acc_seen[i] != acc_used[i]) begin
                acc_used[i] = acc_seen[i];
                vld[i] = 0;
                if (refill) new_rand_job(i);
            end
        end
        if (rnd_mode) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!vld[i] && $urandom_range(0, 3) == 0) new_rand_job(i);
                else if (vld[i] && $urandom_range(0, 31) == 0) vld[i] = 0;
            end
            rdy = ($urandom_range(0, 3) != 0);
        end
        drive();
    endtask

    task automatic wait_hs(input int target, input string nm);
        int n = 0;
        while (hs_cnt < target && n < 3000) begin step(); n++; end
        chk({nm, "_timeout"}, 64'(hs_cnt >= target), 64'd1);
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (m_active && n < 3000) begin step(); n++; end
        chk({nm, "_idle_timeout"}, 64'(m_active), 64'd0);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_req_ready"}, 64'(bus.req_ready), 64'd0);
        chk({nm, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
        chk({nm, "_rsp_id"}, 64'(bus.rsp_id), 64'd0);
        chk({nm, "_rsp_result"}, bus.rsp_result, 64'd0);
        chk({nm, "_avm_rw"}, 64'({bus.avm_read, bus.avm_write}), 64'd0);
        chk({nm, "_avm_addr"}, 64'(bus.avm_address), 64'd0);
        chk({nm, "_avm_wdata"}, 64'(bus.avm_writedata), 64'd0);
        chk({nm, "_busy"}, 64'(bus.busy), 64'd0);
        chk({nm, "_job_count"}, 64'(bus.job_count), 64'd0);
    endtask

    task automatic do_reset();
        reset_n = 0;
        for (int i = 0; i < NUM_REQ; i++) vld[i] = 0;
        drive();
        step();
        chk_zero("reset");
        step();
        reset_n = 1;
    endtask

    initial begin
        int n, hs0, hsr;
        logic [31:0] jc;
        for (int i = 0; i < NUM_REQ; i++) begin
            opa[i] = '0; opb[i] = '0; vld[i] = 0; acc_seen[i] = 0; acc_used[i] = 0;
        end
        drive();
        do_reset();

        // Continuous requests from everyone: strict rotation from requester 0.
        refill = 1;
        for (int i = 0; i < NUM_REQ; i++) new_rand_job(i);
        drive();
        n = 0;
        while (grants.size() < 8 && n < 3000) begin step(); n++; end
        refill = 0;
        for (int i = 0; i < NUM_REQ; i++) vld[i] = 0;
        drive();
        chk("rr_timeout", 64'(grants.size() >= 8), 64'd1);
        for (int j = 0; j < 8 && j < grants.size(); j++) chk("grant_order", 64'(grants[j]), 64'(j % 4));
        wait_idle("rr");

        do_reset();

        // 48,18 through the engine
        new_job(0, 64'd48, 64'd18); drive();
        wait_hs(hs_cnt + 1, "t1");
        chk("t1_result", last_res, 64'd6);
        chk("t1_id", 64'(last_id), 64'd0);
        chk("t1_job_count", 64'(bus.job_count), 64'd1);
        chk("t1_nwrites", 64'(wlog_addr.size()), 64'd4);
        if (wlog_addr.size() == 4) begin
            chk("t1_w0", {29'd0, wlog_addr[0], wlog_data[0]}, {29'd0, 3'd1, 32'd48});
            chk("t1_w1", {29'd0, wlog_addr[1], wlog_data[1]}, {29'd0, 3'd2, 32'd0});
            chk("t1_w2", {29'd0, wlog_addr[2], wlog_data[2]}, {29'd0, 3'd3, 32'd18});
            chk("t1_w3", {29'd0, wlog_addr[3], wlog_data[3]}, {29'd0, 3'd4, 32'd0});
        end

        // 2^32 operands, engine already done on the first poll
        force_lat = 0;
        new_job(2, 64'h1_0000_0000, 64'h1_0000_0000); drive();
        wait_hs(hs_cnt + 1, "t2");
        chk("t2_result", last_res, 64'h1_0000_0000);
        chk("t2_id", 64'(last_id), 64'd2);
        chk("t2_rsp_cycle", 64'(rsp_cyc), 64'd10);
        if (wlog_data.size() == 4) begin
            chk("t2_a_hi", 64'(wlog_data[1]), 64'd1);
            chk("t2_b_hi", 64'(wlog_data[3]), 64'd1);
        end
        force_lat = -1;

        // Bypass
        new_job(1, 64'd0, 64'd35); drive();
        wait_hs(hs_cnt + 1, "t3");
        chk("t3_result", last_res, 64'd35);
        chk("t3_rsp_cycle", 64'(rsp_cyc), 64'd1);
        chk("t3_no_writes", 64'(wlog_addr.size()), 64'd0);
        new_job(1, 64'd0, 64'd0); drive();
        wait_hs(hs_cnt + 1, "t3z");
        chk("t3z_result", last_res, 64'd0);
        chk("t3z_rsp_cycle", 64'(rsp_cyc), 64'd1);

        // Backpressure: response held, no new grant meanwhile
        rdy = 0;
        new_job(3, 64'd7, 64'd21);
        new_job(0, 64'd5, 64'd10);
        drive();
        n = 0;
        while (!bus.rsp_valid && n < 200) begin step(); n++; end
        chk("t4_rsp_seen", 64'(bus.rsp_valid), 64'd1);
        jc = bus.job_count;
        repeat (5) step();
        chk("t4_hold_valid", 64'(bus.rsp_valid), 64'd1);
        chk("t4_hold_result", bus.rsp_result, 64'd7);
        chk("t4_hold_id", 64'(bus.rsp_id), 64'd3);
        chk("t4_hold_count", 64'(bus.job_count), 64'(jc));
        chk("t4_no_grant", 64'(bus.req_ready), 64'd0);
        rdy = 1; drive();
        wait_hs(hs_cnt + 2, "t4");
        chk("t4_second_id", 64'(last_id), 64'd0);
        chk("t4_second_result", last_res, 64'd5);

        // Reset while waiting between polls
        force_lat = 20;
        new_job(0, 64'd1 << 40, 64'd3); drive();
        n = 0;
        while (!(m_active && m_c == 8) && n < 200) begin step(); n++; end
        chk("t5_reach_wait", 64'(m_active && m_c == 8), 64'd1);
        #2;
        reset_n = 0;
        #1;
        chk_zero("t5_abort");
        hs0 = hs_cnt;
        step(); step();
        reset_n = 1;
        force_lat = -1;
        repeat (3) step();
        chk("t5_no_rsp", 64'(hs_cnt), 64'(hs0));
        new_job(2, 64'd1 << 40, 64'd3); drive();
        wait_hs(hs_cnt + 1, "t5");
        chk("t5_result", last_res, 64'd1);
        chk("t5_id", 64'(last_id), 64'd2);
        chk("t5_job_count", 64'(bus.job_count), 64'd1);

        // Random traffic
        hsr = hs_cnt;
        rnd_mode = 1;
        repeat (4000) step();
        rnd_mode = 0;
        for (int i = 0; i < NUM_REQ; i++) vld[i] = 0;
        rdy = 1;
        drive();
        wait_idle("rand");
        chk("rand_progress", 64'(hs_cnt - hsr > 50), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
